chunked_serial_adder: RTL

- Parameterised multi-cycle adder: WIDTH-bit add of a + b + cin, processed CHUNK bits per clock.
- A single carry flop links the chunks.
- Start/busy/done handshake.
- Sits beside the combinational adders in the datapath library; trades latency for area on wide operands.

---
 rtl/chunked_serial_adder_pkg.sv | 18 +
 rtl/chunked_serial_adder_if.sv | 16 +
 rtl/chunked_serial_adder_chunk_adder.sv | 22 ++
 rtl/chunked_serial_adder.sv | 111 +++++++++++
 4 files changed

// File: rtl/chunked_serial_adder_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder.
package chunked_serial_adder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int unsigned num_chunks(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // Chunk index width; never collapses to zero bits when there is a single chunk.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the chunked serial adder.
interface chunked_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/chunked_serial_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple of full adders.
module chunk_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    logic c;

    always_comb begin
        c = ci;
        s = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co = c;
    end
endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit slice per clock, linked by a single carry flop.
module chunked_serial_adder
    import chunked_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    chunked_serial_adder_if.slave bus
);
    localparam int unsigned NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
    localparam int unsigned IDX_W      = idx_width(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_t           state_q, state_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             carry_q, carry_n;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n, sum_q, sum_n;
    logic             cout_q, cout_n, busy_q, busy_n, done_q, done_n;

    logic [CHUNK-1:0] x, y, s;
    logic             co;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .x  (x),
        .y  (y),
        .ci (carry_q),
        .s  (s),
        .co (co)
    );

    // Select the operand slices addressed by the chunk index.
    always_comb begin
        x = '0;
        y = '0;
        for (int unsigned g = 0; g < NUM_CHUNKS; g++) begin
            if (idx_q == IDX_W'(g)) begin
                x = a_q[g*CHUNK +: CHUNK];
                y = b_q[g*CHUNK +: CHUNK];
            end
        end
    end

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        carry_n = carry_q;
        a_n     = a_q;
        b_n     = b_q;
        sum_n   = sum_q;
        cout_n  = cout_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_n     = bus.a;
                    b_n     = bus.b;
                    carry_n = bus.cin;
                    idx_n   = '0;
                    busy_n  = 1'b1;
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int unsigned g = 0; g < NUM_CHUNKS; g++) begin
                    if (idx_q == IDX_W'(g)) sum_n[g*CHUNK +: CHUNK] = s;
                end
                carry_n = co;
                idx_n   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_n  = co;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    idx_n   = '0;
                    state_n = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            carry_q <= carry_n;
            a_q     <= a_n;
            b_q     <= b_n;
            sum_q   <= sum_n;
            cout_q  <= cout_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
